// File: rtl/line_fetcher_pkg.sv
// line_fetcher_pkg
// Shared definitions for the scanline fetcher: FSM state encoding and the
// default VGA geometry (640x480 at 8 pixels per word -> 80 words per line).
package line_fetcher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int LINE_WORDS_DEF = 80;
  localparam int LINES_DEF      = 480;

endpackage

// File: rtl/line_fetcher_skid.sv
// line_fetcher_skid
// Small circular FIFO that absorbs memory read returns so the memory can be
// kept streaming while the downstream FIFO applies backpressure.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write one word (caller guarantees room)
//   pop             remove the oldest word (ignored when empty)
//   pop_data        oldest word, valid while count != 0
//   count           current occupancy
module line_fetcher_skid #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    do_pop = pop && (cnt_q != '0);
    if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = next_ptr(wr_q);
    end
    if (do_pop) rd_d = next_ptr(rd_q);
    case ({push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign pop_data = mem_q[rd_q];
  assign count    = cnt_q;

endmodule

// File: rtl/line_fetcher.sv
// line_fetcher
// Fetches one scanline of framebuffer words per LineStart and streams them,
// in address order, into a downstream FIFO.
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   LineStart           pulse: fetch the next scanline
//   FrameStart          pulse: next line fetched is line 0
//   MemAddr, MemRead    memory read request (one word per MemRead cycle)
//   MemData             read data, MEM_LATENCY cycles after MemRead
//   FifoFull            downstream FIFO full
//   FifoData, FifoPush  downstream FIFO write
//   Busy                line fetch in progress
//   Overrun             sticky: LineStart arrived while Busy
//
// state | meaning
// IDLE  | waiting for LineStart
// FETCH | issuing the line's reads, throttled by outstanding + buffered words
// DRAIN | all reads issued, waiting for returns and skid to empty
module line_fetcher
  import line_fetcher_pkg::*;
#(
  parameter int WWIDTH      = 8,
  parameter int AWIDTH      = 16,
  parameter int LINE_WORDS  = LINE_WORDS_DEF,
  parameter int LINES       = LINES_DEF,
  parameter int MEM_LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LineStart,
  input  logic              FrameStart,
  output logic [AWIDTH-1:0] MemAddr,
  output logic              MemRead,
  input  logic [WWIDTH-1:0] MemData,
  input  logic              FifoFull,
  output logic [WWIDTH-1:0] FifoData,
  output logic              FifoPush,
  output logic              Busy,
  output logic              Overrun
);

  localparam int SKID_DEPTH = MEM_LATENCY + 1;
  localparam int CW         = $clog2(SKID_DEPTH + 1);
  localparam int IW         = $clog2(LINE_WORDS + 1);
  localparam int LAST_BASE  = (LINES - 1) * LINE_WORDS;

  fetch_state_e           state_q, state_d;
  logic [IW-1:0]          issued_q, issued_d;
  logic [AWIDTH-1:0]      base_q, base_d;
  logic [MEM_LATENCY-1:0] inflight_q, inflight_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_pend_q, frame_pend_d;

  logic [CW-1:0]          skid_count;
  logic [WWIDTH-1:0]      skid_data;
  logic                   fifo_push;
  logic                   mem_read;
  int                     occupancy;

  always_comb begin
    fifo_push = (skid_count != '0) && !FifoFull;
    // Words that will eventually sit in the skid: everything in flight plus
    // what is buffered, net of the word leaving this cycle. Keeping this at
    // or below SKID_DEPTH makes skid overflow impossible even if the FIFO
    // stays full, while still allowing one read per cycle when it drains.
    occupancy = int'($countones(inflight_q)) + int'(skid_count) - (fifo_push ? 1 : 0);
    mem_read  = (state_q == FETCH) && (issued_q < IW'(LINE_WORDS)) &&
                (occupancy < SKID_DEPTH);
  end

  always_comb begin
    state_d       = state_q;
    issued_d      = issued_q;
    base_d        = base_q;
    overrun_d     = overrun_q;
    frame_pend_d  = frame_pend_q;
    inflight_d[0] = mem_read;
    for (int i = 1; i < MEM_LATENCY; i++) inflight_d[i] = inflight_q[i-1];

    if (state_q != IDLE) begin
      if (LineStart)  overrun_d    = 1'b1;
      if (FrameStart) frame_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (FrameStart) base_d = '0;
        if (LineStart) begin
          state_d  = FETCH;
          issued_d = '0;
        end
      end
      FETCH: begin
        if (mem_read) begin
          issued_d = issued_q + 1'b1;
          if (issued_q == IW'(LINE_WORDS - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight_q == '0 && skid_count == '0) begin
          state_d      = IDLE;
          frame_pend_d = 1'b0;
          if (frame_pend_q || FrameStart || base_q == AWIDTH'(LAST_BASE))
            base_d = '0;
          else
            base_d = base_q + AWIDTH'(LINE_WORDS);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      issued_q     <= '0;
      base_q       <= '0;
      inflight_q   <= '0;
      overrun_q    <= 1'b0;
      frame_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      base_q       <= base_d;
      inflight_q   <= inflight_d;
      overrun_q    <= overrun_d;
      frame_pend_q <= frame_pend_d;
    end
  end

  line_fetcher_skid #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (WWIDTH)
  ) u_skid (
    .clk       (Clk),
    .rst       (Reset),
    .push      (inflight_q[MEM_LATENCY-1]),
    .push_data (MemData),
    .pop       (fifo_push),
    .pop_data  (skid_data),
    .count     (skid_count)
  );

  assign MemAddr  = base_q + AWIDTH'(issued_q);
  assign MemRead  = mem_read;
  assign FifoPush = fifo_push;
  assign FifoData = fifo_push ? skid_data : '0;
  assign Busy     = (state_q != IDLE);
  assign Overrun  = overrun_q;

endmodule

// File: tb/tb_line_fetcher.sv
module tb_line_fetcher;
  localparam int WW = 8;
  localparam int AW = 16;
  localparam int LW = 80;
  localparam int NL = 480;
  localparam int ML = 2;

  logic          Clk, Reset, LineStart, FrameStart, FifoFull;
  logic [AW-1:0] MemAddr;
  logic          MemRead;
  logic [WW-1:0] MemData;
  logic [WW-1:0] FifoData;
  logic          FifoPush, Busy, Overrun;

  line_fetcher #(
    .WWIDTH(WW), .AWIDTH(AW), .LINE_WORDS(LW), .LINES(NL), .MEM_LATENCY(ML)
  ) dut (
    .Clk(Clk), .Reset(Reset), .LineStart(LineStart), .FrameStart(FrameStart),
    .MemAddr(MemAddr), .MemRead(MemRead), .MemData(MemData),
    .FifoFull(FifoFull), .FifoData(FifoData), .FifoPush(FifoPush),
    .Busy(Busy), .Overrun(Overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int line_idx = 0;

  // Memory model and bus monitor, all sampled mid-cycle.
  logic [AW-1:0] pa [0:ML];
  bit            pv [0:ML];
  logic [AW-1:0] rd_q[$];
  int            rd_cyc_q[$];
  logic [WW-1:0] push_q[$];
  int            push_cyc_q[$];
  int            push_full = 0;
  int            rd_tot = 0, push_tot = 0, max_outst = 0;
  int            ls_cyc = 0;

  initial begin
    for (int k = 0; k <= ML; k++) begin pa[k] = '0; pv[k] = 1'b0; end
    MemData = '0;
  end

  always @(negedge Clk) begin
    for (int k = ML; k > 0; k--) begin pa[k] = pa[k-1]; pv[k] = pv[k-1]; end
    pa[0] = MemAddr;
    pv[0] = MemRead && !Reset;
    MemData = pv[ML] ? pa[ML][7:0] : WW'($urandom);
    if (Reset) begin
      rd_tot = 0;
      push_tot = 0;
    end else begin
      if (MemRead) begin
        rd_q.push_back(MemAddr); rd_cyc_q.push_back(cyc); rd_tot++;
      end
      if (FifoPush) begin
        push_q.push_back(FifoData); push_cyc_q.push_back(cyc); push_tot++;
        if (FifoFull) push_full++;
      end
      if (rd_tot - push_tot > max_outst) max_outst = rd_tot - push_tot;
      if (LineStart && !Busy) ls_cyc = cyc;
    end
  end

  function automatic int model_base(input int idx);
    return (idx % NL) * LW;
  endfunction

  function automatic int addr_errs(input int rm, input int base);
    int e = 0;
    if (rd_q.size() - rm != LW) e++;
    for (int i = 0; i < LW; i++)
      if (rm + i >= rd_q.size() || rd_q[rm+i] !== AW'(base + i)) e++;
    return e;
  endfunction

  function automatic int data_errs(input int pm, input int base);
    int e = 0;
    if (push_q.size() - pm != LW) e++;
    for (int i = 0; i < LW; i++)
      if (pm + i >= push_q.size() || push_q[pm+i] !== WW'((base + i) % 256)) e++;
    return e;
  endfunction

  int rm, pm, busy_low_cyc;

  // mode 0: FifoFull low; 1: random backpressure; 2: full for 10 cycles mid-line.
  // inj >= 0: pulse LineStart+FrameStart that many cycles into the line.
  task automatic run_line(input bit fs, input int mode, input int inj);
    int n = 0;
    rm = rd_q.size();
    pm = push_q.size();
    @(posedge Clk); #1;
    LineStart = 1'b1; FrameStart = fs;
    @(posedge Clk); #1;
    LineStart = 1'b0; FrameStart = 1'b0;
    while (Busy && n < 2000) begin
      LineStart  = (n == inj);
      FrameStart = (n == inj);
      case (mode)
        1:       FifoFull = ($urandom_range(0, 2) == 0);
        2:       FifoFull = (n >= 20 && n < 30);
        default: FifoFull = 1'b0;
      endcase
      @(posedge Clk); #1;
      n++;
    end
    LineStart = 1'b0; FrameStart = 1'b0; FifoFull = 1'b0;
    busy_low_cyc = cyc;
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL line_timeout: Busy still %0b after %0d cycles, required 0", Busy, n);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; LineStart = 0; FrameStart = 0; FifoFull = 0;
    repeat (3) @(posedge Clk);
    #1;
    checks += 6;
    if (MemAddr !== '0) begin failures++; $display("FAIL reset_addr: got %0d want 0", MemAddr); end
    if (MemRead !== 1'b0) begin failures++; $display("FAIL reset_read: got %b want 0", MemRead); end
    if (FifoData !== '0) begin failures++; $display("FAIL reset_fdata: got %0d want 0", FifoData); end
    if (FifoPush !== 1'b0) begin failures++; $display("FAIL reset_push: got %b want 0", FifoPush); end
    if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", Busy); end
    if (Overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", Overrun); end
    @(posedge Clk); #1;
    Reset = 1'b0;
    line_idx = 0;
  endtask

  task automatic test_single_line();
    int e;
    run_line(0, 0, -1);
    checks += 6;
    e = addr_errs(rm, model_base(line_idx));
    if (e !== 0) begin failures++; $display("FAIL line0_addr: %0d bad addresses, want 0", e); end
    e = data_errs(pm, model_base(line_idx));
    if (e !== 0) begin failures++; $display("FAIL line0_data: %0d bad words, want 0", e); end
    if (rd_cyc_q[rm] - ls_cyc !== 1) begin
      failures++; $display("FAIL first_read_latency: got %0d want 1", rd_cyc_q[rm] - ls_cyc);
    end
    if (push_cyc_q[pm] - rd_cyc_q[rm] !== ML + 1) begin
      failures++; $display("FAIL first_push_latency: got %0d want %0d", push_cyc_q[pm] - rd_cyc_q[rm], ML + 1);
    end
    if (push_cyc_q[push_cyc_q.size()-1] - push_cyc_q[pm] !== LW - 1) begin
      failures++; $display("FAIL throughput: push span %0d want %0d",
                           push_cyc_q[push_cyc_q.size()-1] - push_cyc_q[pm], LW - 1);
    end
    if (Overrun !== 1'b0 || busy_low_cyc - push_cyc_q[push_cyc_q.size()-1] > 3) begin
      failures++; $display("FAIL line0_end: overrun %b, busy fell %0d cycles after last push, want 0 and <=3",
                           Overrun, busy_low_cyc - push_cyc_q[push_cyc_q.size()-1]);
    end
    line_idx++;
  endtask

  task automatic test_second_line();
    int e;
    run_line(0, 0, -1);
    checks += 2;
    e = addr_errs(rm, model_base(line_idx));
    if (e !== 0) begin failures++; $display("FAIL line1_addr: %0d bad addresses, want 0", e); end
    e = data_errs(pm, model_base(line_idx));
    if (e !== 0) begin failures++; $display("FAIL line1_data: %0d bad words, want 0", e); end
    line_idx++;
  endtask

  task automatic test_backpressure();
    int e, pf0;
    for (int mode = 2; mode >= 1; mode--) begin
      pf0 = push_full;
      run_line(0, mode, -1);
      checks += 3;
      e = addr_errs(rm, model_base(line_idx));
      if (e !== 0) begin failures++; $display("FAIL bp%0d_addr: %0d bad addresses, want 0", mode, e); end
      e = data_errs(pm, model_base(line_idx));
      if (e !== 0) begin failures++; $display("FAIL bp%0d_data: %0d bad words, want 0", mode, e); end
      if (push_full - pf0 !== 0) begin
        failures++; $display("FAIL bp%0d_push_while_full: got %0d want 0", mode, push_full - pf0);
      end
      line_idx++;
    end
    checks++;
    if (max_outst > ML + 1) begin
      failures++; $display("FAIL bp_outstanding: got %0d want <= %0d", max_outst, ML + 1);
    end
  endtask

  task automatic test_overrun_frame();
    int e;
    run_line(0, 1, 15);
    checks += 3;
    e = addr_errs(rm, model_base(line_idx));
    if (e !== 0) begin failures++; $display("FAIL ovr_addr: %0d bad addresses, want 0", e); end
    e = data_errs(pm, model_base(line_idx));
    if (e !== 0) begin failures++; $display("FAIL ovr_data: %0d bad words, want 0", e); end
    if (Overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b want 1", Overrun); end
    line_idx = 0;
    run_line(0, 0, -1);
    checks += 2;
    if (rd_q[rm] !== AW'(0)) begin failures++; $display("FAIL frame_midline_base: got %0d want 0", rd_q[rm]); end
    if (Overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b want 1", Overrun); end
    line_idx++;
  endtask

  task automatic test_frame_wrap();
    int e, tot = 0;
    line_idx = 0;
    run_line(1, 0, -1);
    checks++;
    if (rd_q[rm] !== AW'(0)) begin failures++; $display("FAIL frame_line_same_cycle: got %0d want 0", rd_q[rm]); end
    tot += addr_errs(rm, model_base(line_idx)) + data_errs(pm, model_base(line_idx));
    line_idx++;
    while (line_idx <= NL) begin
      run_line(0, 0, -1);
      tot += addr_errs(rm, model_base(line_idx)) + data_errs(pm, model_base(line_idx));
      if (line_idx == NL - 1) begin
        checks++;
        if (rd_q[rm] !== AW'(38320)) begin failures++; $display("FAIL line479_base: got %0d want 38320", rd_q[rm]); end
      end
      if (line_idx == NL) begin
        checks++;
        if (rd_q[rm] !== AW'(0)) begin failures++; $display("FAIL line480_base: got %0d want 0", rd_q[rm]); end
      end
      line_idx++;
    end
    checks++;
    if (tot !== 0) begin failures++; $display("FAIL frame_all_lines: %0d errors, want 0", tot); end
  endtask

  task automatic test_reset_midline();
    int e, n = 0;
    rm = rd_q.size();
    @(posedge Clk); #1; LineStart = 1'b1;
    @(posedge Clk); #1; LineStart = 1'b0;
    while (rd_q.size() - rm < 40 && n < 200) begin @(posedge Clk); #1; n++; end
    Reset = 1'b1;
    #1;
    checks += 7;
    if (n >= 200) begin failures++; $display("FAIL rst_mid_wait: only %0d reads, want 40", rd_q.size() - rm); end
    if (MemAddr !== '0) begin failures++; $display("FAIL rst_mid_addr: got %0d want 0", MemAddr); end
    if (MemRead !== 1'b0) begin failures++; $display("FAIL rst_mid_read: got %b want 0", MemRead); end
    if (FifoData !== '0) begin failures++; $display("FAIL rst_mid_fdata: got %0d want 0", FifoData); end
    if (FifoPush !== 1'b0) begin failures++; $display("FAIL rst_mid_push: got %b want 0", FifoPush); end
    if (Busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b want 0", Busy); end
    if (Overrun !== 1'b0) begin failures++; $display("FAIL rst_mid_overrun: got %b want 0", Overrun); end
    repeat (2) @(posedge Clk);
    #1; Reset = 1'b0;
    line_idx = 0;
    run_line(0, 0, -1);
    checks += 2;
    e = addr_errs(rm, model_base(line_idx));
    if (e !== 0) begin failures++; $display("FAIL rst_mid_next_addr: %0d bad addresses, want 0", e); end
    e = data_errs(pm, model_base(line_idx));
    if (e !== 0) begin failures++; $display("FAIL rst_mid_next_data: %0d bad words, want 0", e); end
    line_idx++;
  endtask

  initial begin
    Reset = 1'b1; LineStart = 1'b0; FrameStart = 1'b0; FifoFull = 1'b0;
    test_reset();
    test_single_line();
    test_second_line();
    test_backpressure();
    test_overrun_frame();
    test_reset();
    test_frame_wrap();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
